// File: rtl/sr_cmd_sequencer_pkg.sv
// rtl/sr_cmd_sequencer_pkg.sv - shared op codes and FSM state encodings for the SR command sequencer
//
// Purpose : single home for the command op codes and the 2-bit state
//           encoding, so the top, the interface and the bench agree on them.
// Contents: op_e    - 00 hold, 01 set, 10 reset, 11 toggle
//           state_e - IDLE -> DRIVE -> CHECK -> RESP
package sr_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SET  = 2'b01,
        OP_RST  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    localparam int OP_W = 2;

    // Human-readable op name for debug prints in simulation environments.
    function automatic string op_name(input logic [OP_W-1:0] op);
        case (op)
            OP_HOLD: return "hold";
            OP_SET:  return "set";
            OP_RST:  return "reset";
            default: return "toggle";
        endcase
    endfunction

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// rtl/sr_cmd_sequencer_if.sv - command/response handshake and SR flop bus
//
// Purpose : bundles the command handshake, the s/r drive bus, the q
//           feedback and the response strobe into one port.
// Signals : cmd_valid/cmd_ready/cmd_op/cmd_mask - command channel
//           s/r                                 - set/reset pulses to flops
//           q_fb                                - flop outputs fed back
//           rsp_valid/rsp_err                   - one-cycle response
// Modports: master - command source / flop bank side (drives cmd, q_fb)
//           slave  - the sequencer
interface sr_cmd_sequencer_if
    import sr_cmd_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q_fb;
    logic             rsp_valid;
    logic             rsp_err;

    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_op,
        output cmd_mask,
        input  s,
        input  r,
        output q_fb,
        input  rsp_valid,
        input  rsp_err
    );

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_op,
        input  cmd_mask,
        output s,
        output r,
        input  q_fb,
        output rsp_valid,
        output rsp_err
    );

endinterface

// File: rtl/sr_cmd_sequencer.sv
// rtl/sr_cmd_sequencer.sv - drives one-cycle s/r pulses to an SR flop bank and verifies the result
//
// Purpose : accepts hold/set/reset/toggle commands, pulses s/r for exactly
//           one cycle (never s=r=1 on any bit), then compares the masked
//           flop feedback against the expected value for up to TIMEOUT
//           cycles and returns a one-cycle ok/err response.
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-high reset
//           bus - sr_cmd_sequencer_if.slave (command, s/r, q_fb, response)
// Params  : WIDTH   - number of SR channels (1..32)
//           TIMEOUT - compare cycles allowed before err (>=1)
//           CW      - timeout counter width, must hold TIMEOUT
module sr_cmd_sequencer
    import sr_cmd_sequencer_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 4,
    parameter int CW      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_cmd_sequencer_if.slave    bus
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;

    op_e              op;
    logic             accept;
    logic             match;

    assign op     = op_e'(bus.cmd_op);
    assign accept = bus.cmd_valid && (state_q == ST_IDLE);
    // Only masked channels take part in the comparison; mask=0 always matches.
    assign match  = ((bus.q_fb & mask_q) == (exp_q & mask_q));

    // State and datapath registers. The async reset clears s/r at once so an
    // aborted command cannot leave a pulse on the flop bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            r_q         <= '0;
            mask_q      <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            r_q         <= r_d;
            mask_q      <= mask_d;
            exp_q       <= exp_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and next-output logic. s/r default to zero so they are only
    // ever non-zero for the single DRIVE cycle following an accept.
    always_comb begin
        state_d     = state_q;
        s_d         = '0;
        r_d         = '0;
        mask_d      = mask_q;
        exp_d       = exp_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mask_d  = bus.cmd_mask;
                    state_d = ST_DRIVE;
                    unique case (op)
                        OP_SET: begin
                            exp_d = '1;
                            s_d   = bus.cmd_mask;
                        end
                        OP_RST: begin
                            exp_d = '0;
                            r_d   = bus.cmd_mask;
                        end
                        OP_TGL: begin
                            // Each bit gets either s or r depending on its
                            // current value, so s&r stays zero per bit.
                            exp_d = ~bus.q_fb;
                            s_d   = bus.cmd_mask & ~bus.q_fb;
                            r_d   = bus.cmd_mask &  bus.q_fb;
                        end
                        OP_HOLD: begin
                            exp_d = bus.q_fb;
                        end
                    endcase
                end
            end

            ST_DRIVE: begin
                cnt_d   = '0;
                state_d = ST_CHECK;
            end

            ST_CHECK: begin
                if (match) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    // Counter stops at CNT_LAST; the branch above exits first.
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
